// File: rtl/sm3_msg_expand.sv
// ---------------------------------------------------------------------------
// sm3_msg_expand
//
// SM3 message-expansion stage. Takes one padded 512-bit block as 16
// big-endian 32-bit words. Then it emits the pair (W_j, W'_j = W_j ^ W_{j+4})
// once per output handshake, for j = 0 .. ROUNDS-1. The next stage is the
// compression round.
//
// The expansion runs over a 16-word sliding window. win[0] always holds W_j.
// Each accepted output shifts the window down by one word. The newly
// expanded word W_{j+16} enters at win[15]. The window always holds
// W_j .. W_{j+15}, so W_{j+4} sits in win[4] for every j up to 63. For that
// reason the last rounds need no special case.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. Once the producer raises valid, it holds
// valid and its payload stable until that transfer happens. The consumer may
// move ready freely.
//
// Parameters:
//   ROUNDS      number of (W_j, W'_j) pairs emitted per block, 16..64
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (clears everything)
//   din_valid   upstream message word valid
//   din_ready   high while the block is loading (state LOAD)
//   din_data    message word, W_0 first, W_15 last
//   wout_valid  W_j / W'_j valid (state EXPAND)
//   wout_ready  compression stage accepts the current round
//   wout_w      W_j
//   wout_wp     W'_j = W_j ^ W_{j+4}
//   wout_idx    round index j
//   wout_last   high with j == ROUNDS-1
//   busy        high while expanding or while a partial block is loaded
// ---------------------------------------------------------------------------
module sm3_msg_expand #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    output logic        wout_valid,
    input  logic        wout_ready,
    output logic [31:0] wout_w,
    output logic [31:0] wout_wp,
    output logic [5:0]  wout_idx,
    output logic        wout_last,
    output logic        busy
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [0:0] ST_LOAD   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]  state;      // ST_LOAD / ST_EXPAND; a checker can probe it
    logic [3:0]  load_cnt;   // words accepted so far in LOAD
    logic [5:0]  round_idx;  // j
    logic        last_q;     // registered (round_idx == LAST_IDX) in EXPAND
    logic [31:0] win [16];   // sliding window, win[0] = W_j

    // -----------------------------------------------------------------------
    // Handshake strobes
    // -----------------------------------------------------------------------
    logic load_fire;
    logic out_fire;
    logic load_done;
    logic block_done;

    assign load_fire  = din_valid  & din_ready;
    assign out_fire   = wout_valid & wout_ready;
    assign load_done  = load_fire & (load_cnt == 4'd15);
    assign block_done = out_fire  & (round_idx == LAST_IDX);

    // -----------------------------------------------------------------------
    // Next-word generation. Everything is XOR / 32-bit circular rotate.
    // In index terms the new word is W_{j+16}, and it uses
    // W_j, W_{j+7}, W_{j+13}, W_{j+3} and W_{j+10}.
    // -----------------------------------------------------------------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    logic [31:0] x_term;
    logic [31:0] new_word;

    always_comb begin
        x_term   = win[0] ^ win[7] ^ rotl(win[13], 15);
        new_word = p1(x_term) ^ rotl(win[3], 7) ^ win[10];
    end

    // -----------------------------------------------------------------------
    // Control: state, load counter, round index, last flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            load_cnt  <= 4'd0;
            round_idx <= 6'd0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        // Wraps to 0 on the 16th word, which is the
                        // "load count = 0" condition for the next block.
                        load_cnt <= load_cnt + 4'd1;
                    end
                    if (load_done) begin
                        state     <= ST_EXPAND;
                        round_idx <= 6'd0;
                        last_q    <= (LAST_IDX == 6'd0);
                    end
                end
                ST_EXPAND: begin
                    if (out_fire) begin
                        round_idx <= round_idx + 6'd1;
                        // Look ahead one round so that wout_last is a flop.
                        last_q    <= ((round_idx + 6'd1) == LAST_IDX);
                    end
                    if (block_done) begin
                        // The next block starts loading only after the last
                        // round is taken. Two blocks never overlap.
                        state    <= ST_LOAD;
                        load_cnt <= 4'd0;
                        last_q   <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_LOAD;
                    load_cnt <= 4'd0;
                    last_q   <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Window: direct write while loading, shift by one per output handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else if (state == ST_LOAD) begin
            if (load_fire) begin
                win[load_cnt] <= din_data;
            end
        end else if (out_fire) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= new_word;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Each one is a register, a state decode, or a single XOR of
    // registers. None of them depends on the new-word logic.
    // -----------------------------------------------------------------------
    assign din_ready  = (state == ST_LOAD);
    assign wout_valid = (state == ST_EXPAND);
    assign wout_w     = win[0];
    assign wout_wp    = win[0] ^ win[4];
    assign wout_idx   = round_idx;
    assign wout_last  = last_q;
    assign busy       = (state != ST_LOAD) || (load_cnt != 4'd0);

endmodule

// File: tb/tb_sm3_msg_expand.sv
// ---------------------------------------------------------------------------
// tb_sm3_msg_expand
//
// Self-checking bench for sm3_msg_expand. It runs two instances that share
// the clock and reset:
//   u_dut    ROUNDS = 64
//   u_dut16  ROUNDS = 16
// The signal sel chooses which instance gets din_valid and which one the
// monitor observes.
//
// When a block starts loading, the bench computes its golden expansion in
// index form and pushes the expected {last, idx, W, W'} entries to exp_q.
// The monitor pops and compares one entry per output handshake.
// ---------------------------------------------------------------------------
module tb_sm3_msg_expand;

    localparam int EW = 71;  // {last, idx[5:0], w[31:0], wp[31:0]}

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // DUT signals
    // -----------------------------------------------------------------------
    logic        din_valid;
    logic [31:0] din_data;
    logic        wout_ready;
    logic        sel;

    logic        a_din_ready, a_valid, a_last, a_busy;
    logic [31:0] a_w, a_wp;
    logic [5:0]  a_idx;

    logic        b_din_ready, b_valid, b_last, b_busy;
    logic [31:0] b_w, b_wp;
    logic [5:0]  b_idx;

    logic din_valid_a, din_valid_b;

    assign din_valid_a = din_valid & ~sel;
    assign din_valid_b = din_valid & sel;

    sm3_msg_expand #(.ROUNDS(64)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid_a),
        .din_ready  (a_din_ready),
        .din_data   (din_data),
        .wout_valid (a_valid),
        .wout_ready (wout_ready),
        .wout_w     (a_w),
        .wout_wp    (a_wp),
        .wout_idx   (a_idx),
        .wout_last  (a_last),
        .busy       (a_busy)
    );

    sm3_msg_expand #(.ROUNDS(16)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid_b),
        .din_ready  (b_din_ready),
        .din_data   (din_data),
        .wout_valid (b_valid),
        .wout_ready (wout_ready),
        .wout_w     (b_w),
        .wout_wp    (b_wp),
        .wout_idx   (b_idx),
        .wout_last  (b_last),
        .busy       (b_busy)
    );

    logic        obs_din_ready, obs_valid, obs_last, obs_busy;
    logic [31:0] obs_w, obs_wp;
    logic [5:0]  obs_idx;

    assign obs_din_ready = sel ? b_din_ready : a_din_ready;
    assign obs_valid     = sel ? b_valid     : a_valid;
    assign obs_last      = sel ? b_last      : a_last;
    assign obs_busy      = sel ? b_busy      : a_busy;
    assign obs_w         = sel ? b_w         : a_w;
    assign obs_wp        = sel ? b_wp        : a_wp;
    assign obs_idx       = sel ? b_idx       : a_idx;

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_out = 0;
    bit            rand_ready = 1'b0;
    bit            abc_mode   = 1'b0;
    bit            stall_pend = 1'b0;
    bit            after_last = 1'b0;
    logic [EW-1:0] stall_snap;
    logic [31:0]   gw [68];

    logic [511:0] abc_blk;
    assign abc_blk = {32'h61626380, 448'h0, 32'h00000018};

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Golden model, index form:
    // W_j = P1(W_{j-16} ^ W_{j-9} ^ rotl(W_{j-3},15)) ^ rotl(W_{j-13},7) ^ W_{j-6}
    // -----------------------------------------------------------------------
    function automatic logic [31:0] g_rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic gold(input logic [511:0] blk);
        logic [31:0] t;
        for (int i = 0; i < 16; i++) gw[i] = blk[511 - 32*i -: 32];
        for (int j = 16; j < 68; j++) begin
            t = gw[j-16] ^ gw[j-9] ^ g_rotl(gw[j-3], 15);
            t = t ^ g_rotl(t, 15) ^ g_rotl(t, 23);
            gw[j] = t ^ g_rotl(gw[j-13], 7) ^ gw[j-6];
        end
    endtask

    task automatic push_exp(input logic [511:0] blk, input int rounds);
        logic [5:0] idx;
        gold(blk);
        for (int j = 0; j < rounds; j++) begin
            idx = 6'(j);
            exp_q.push_back({(j == rounds - 1), idx, gw[j], gw[j] ^ gw[j+4]});
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom;
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // Driver: load one block. The call starts from any time point and
    // returns at the negedge after the 16th word handshake.
    // -----------------------------------------------------------------------
    task automatic load_block(input logic [511:0] blk, input int rounds,
                              input int gap_after, input int gap_len,
                              input bit hold_valid);
        bit ok;
        push_exp(blk, rounds);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            din_valid = 1'b1;
            din_data  = blk[511 - 32*i -: 32];
            ok = 1'b0;
            for (int t = 0; t < 300 && !ok; t++) begin
                @(negedge clk);
                ok = obs_din_ready;
            end
            if (!ok) begin
                check("load_timeout", 0, 1);
                din_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == 0) check("busy_loading", obs_busy, 1);
            if (i == gap_after) begin
                din_valid = 1'b0;
                din_data  = 32'hDEADBEEF;
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
        if (!hold_valid) din_valid = 1'b0;
        @(negedge clk);
        check("first_valid", obs_valid, 1);
        check("first_idx", obs_idx, 0);
    endtask

    task automatic drain(input string tag, input int expect_n);
        bit ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0);
        end
        if (!ok) check("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        check(tag, n_out, expect_n);
        n_out = 0;
    endtask

    // -----------------------------------------------------------------------
    // Monitor and output-ready driver
    // -----------------------------------------------------------------------
    task automatic ready_drv();
        forever begin
            @(posedge clk); #1;
            wout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic monitor();
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            got = {obs_last, obs_idx, obs_w, obs_wp};
            if (rst) begin
                stall_pend = 1'b0;
                after_last = 1'b0;
            end else begin
                check("ready_vs_valid", obs_din_ready, !obs_valid);
                if (after_last) begin
                    check("reload_ready", obs_din_ready, 1);
                    after_last = 1'b0;
                end
                if (stall_pend) begin
                    check("stall_valid", obs_valid, 1);
                    check("stall_hold", got, stall_snap);
                    stall_pend = 1'b0;
                end
                if (obs_valid && wout_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("spurious_out", {1'b1, got}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("w_pair", got, e);
                    end
                    if (abc_mode && !sel) begin
                        case (obs_idx)
                            6'd0:  begin
                                check("abc_w0", obs_w, 32'h61626380);
                                check("abc_wp0", obs_wp, 32'h61626380);
                            end
                            6'd16: check("abc_w16", obs_w, 32'h9092E200);
                            6'd17: check("abc_w17", obs_w, 32'h00000000);
                            6'd18: check("abc_w18", obs_w, 32'h000C0606);
                            6'd19: check("abc_w19", obs_w, 32'h719C70ED);
                            default: ;
                        endcase
                    end
                    if (obs_last) after_last = 1'b1;
                end else if (obs_valid) begin
                    stall_pend = 1'b1;
                    stall_snap = got;
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        bit found;
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_data   = 32'd0;
        wout_ready = 1'b0;
        sel        = 1'b0;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        #12;
        check("rst_din_ready", obs_din_ready, 1);
        check("rst_valid", obs_valid, 0);
        check("rst_w", obs_w, 0);
        check("rst_wp", obs_wp, 0);
        check("rst_idx", obs_idx, 0);
        check("rst_last", obs_last, 0);
        check("rst_busy", obs_busy, 0);
        @(posedge clk); #1 rst = 1'b0;

        // "abc" block, output always ready
        abc_mode = 1'b1;
        load_block(abc_blk, 64, -1, 0, 1'b0);
        drain("abc_count", 64);

        // Same block, random output back-pressure
        rand_ready = 1'b1;
        load_block(abc_blk, 64, -1, 0, 1'b0);
        drain("stall_count", 64);
        rand_ready = 1'b0;

        // Gap of 3 cycles after word 5
        load_block(abc_blk, 64, 5, 3, 1'b0);
        drain("gap_count", 64);
        abc_mode = 1'b0;

        // Back-to-back random blocks, din_valid held high
        load_block(rand_blk(), 64, -1, 0, 1'b1);
        load_block(rand_blk(), 64, -1, 0, 1'b0);
        drain("b2b_count", 128);

        // Reset in the middle of expansion at idx 30
        load_block(abc_blk, 64, -1, 0, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            if (obs_valid && obs_idx == 6'd30) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("idx30_timeout", 0, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_din_ready", obs_din_ready, 1);
        check("mid_rst_valid", obs_valid, 0);
        check("mid_rst_w", obs_w, 0);
        check("mid_rst_wp", obs_wp, 0);
        check("mid_rst_idx", obs_idx, 0);
        check("mid_rst_last", obs_last, 0);
        check("mid_rst_busy", obs_busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        n_out = 0;
        abc_mode = 1'b1;
        load_block(abc_blk, 64, -1, 0, 1'b0);
        drain("post_rst_count", 64);
        abc_mode = 1'b0;

        // ROUNDS = 16 instance, random block, random back-pressure
        sel = 1'b1;
        rand_ready = 1'b1;
        load_block(rand_blk(), 16, -1, 0, 1'b0);
        drain("r16_count", 16);
        rand_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
